// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants and types for the LBP scan engine.
//   LBP_IMG_LOG2 / LBP_ADDR_W : default image geometry (128x128, {y,x} address)
//   state_t                   : scan controller FSM states
//   NB_ROW / NB_COL           : window position of neighbour bit k (row 0 = y-1, col 0 = x-1)
package lbp_pkg;

  localparam int LBP_IMG_LOG2 = 7;
  localparam int LBP_ADDR_W   = 2 * LBP_IMG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_CLEAR,
    S_LOAD,
    S_EVAL,
    S_DONE
  } state_t;

  localparam int NUM_NB = 8;

  // Neighbour bit indices into the LBP code.
  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_W  = 3;
  localparam int NB_E  = 4;
  localparam int NB_SW = 5;
  localparam int NB_S  = 6;
  localparam int NB_SE = 7;

  // Element [k] gives the window row / column of neighbour k.
  localparam logic [NUM_NB-1:0][1:0] NB_ROW =
    {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [NUM_NB-1:0][1:0] NB_COL =
    {2'd2, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/lbp_scan_ctrl_if.sv
// lbp_scan_ctrl_if: gray-memory read port and LBP-memory write port.
//   gray_req/gray_addr -> gray memory, gray_ready/gray_data <- gray memory
//   lbp_valid/lbp_addr/lbp_data -> LBP memory (sampled at negedge)
//   master: scan controller side; slave: memory side.
interface lbp_scan_ctrl_if #(
  parameter int ADDR_W = lbp_pkg::LBP_ADDR_W
);
  logic              gray_req;
  logic              gray_ready;
  logic [ADDR_W-1:0] gray_addr;
  logic [7:0]        gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;

  modport master (
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    input  gray_ready, gray_data
  );

  modport slave (
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    output gray_ready, gray_data
  );
endinterface

// File: rtl/lbp_code_calc.sv
// lbp_code_calc: combinational LBP code of one 3x3 window.
//   win  : 9 pixels, win[row][col], row 0 = y-1, col 0 = x-1, centre win[1][1]
//   code : bit k = (neighbour k >= centre), unsigned
module lbp_code_calc
  import lbp_pkg::*;
(
  input  logic [2:0][2:0][7:0] win,
  output logic [7:0]           code
);

  for (genvar k = 0; k < NUM_NB; k++) begin : g_nb
    assign code[k] = (win[NB_ROW[k]][NB_COL[k]] >= win[1][1]);
  end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl: raster scan sequencer for the LBP engine.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : lbp_scan_ctrl_if.master (gray read handshake, LBP write port)
//   finish     : scan complete, held until reset
// Optional macro LBP_BORDER_CLEAR_EN: a CLEAR phase writes 0 to every border
// address before the scan; without it the border is never written.
module lbp_scan_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_LOG2 = LBP_IMG_LOG2,
  parameter int ADDR_W   = 2 * IMG_LOG2
) (
  input  logic            clk,
  input  logic            reset,
  lbp_scan_ctrl_if.master bus,
  output logic            finish
);

  localparam logic [IMG_LOG2-1:0] ONE  = IMG_LOG2'(1);
  localparam logic [IMG_LOG2-1:0] LAST = IMG_LOG2'(2**IMG_LOG2 - 2);

  state_t state, nstate;

  // Centre pixel of the current window.
  logic [IMG_LOG2-1:0] x, y;
  // Fetch counters: fr = window row (y-1..y+1), fc = window column on a row start.
  logic [1:0] fr, fc;
  // Row start: the whole window is fetched instead of only the new right column.
  logic full;
  logic [2:0][2:0][7:0] win;
  logic [7:0] code;

  logic                accept, last_rd, row_end, scan_end;
  logic [1:0]          wcol;
  logic [IMG_LOG2-1:0] rd_x, rd_y;

  assign accept   = (state == S_LOAD) && bus.gray_ready;
  assign last_rd  = accept && (fr == 2'd2) && (!full || fc == 2'd2);
  assign row_end  = (x == LAST);
  assign scan_end = row_end && (y == LAST);
  assign wcol     = full ? fc : 2'd2;
  assign rd_y     = y + {{(IMG_LOG2-2){1'b0}}, fr} - ONE;
  assign rd_x     = full ? (x + {{(IMG_LOG2-2){1'b0}}, fc} - ONE) : (x + ONE);
  assign finish   = (state == S_DONE);

  lbp_code_calc u_calc (
    .win  (win),
    .code (code)
  );

`ifdef LBP_BORDER_CLEAR_EN
  // Border order: row 0, last row, then (col 0, last col) for rows 1..side-2.
  localparam int CW = IMG_LOG2 + 2;
  localparam logic [CW-1:0] SIDE1    = CW'(2**IMG_LOG2);
  localparam logic [CW-1:0] SIDE2    = CW'(2 * (2**IMG_LOG2));
  localparam logic [CW-1:0] CLR_LAST = CW'(4 * (2**IMG_LOG2) - 5);

  logic [CW-1:0]       clr_cnt;
  logic [IMG_LOG2-1:0] clr_x, clr_y;
  logic                clr_last;

  assign clr_last = (clr_cnt == CLR_LAST);

  always_comb begin
    clr_x = clr_cnt[IMG_LOG2-1:0];
    clr_y = '0;
    if (clr_cnt < SIDE1) begin
      clr_y = '0;
    end else if (clr_cnt < SIDE2) begin
      clr_y = '1;
    end else begin
      // cnt = 2*side + j: bits [IMG_LOG2:1] give j/2, bit 0 selects the side.
      clr_y = clr_cnt[IMG_LOG2:1] + ONE;
      clr_x = {IMG_LOG2{clr_cnt[0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                 clr_cnt <= '0;
    else if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate        = state;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.lbp_valid = 1'b0;
    bus.lbp_addr  = '0;
    bus.lbp_data  = '0;
    case (state)
      S_IDLE: nstate = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (bus.gray_ready) begin
`ifdef LBP_BORDER_CLEAR_EN
          nstate = S_CLEAR;
`else
          nstate = S_LOAD;
`endif
        end
      end
`ifdef LBP_BORDER_CLEAR_EN
      S_CLEAR: begin
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = {clr_y, clr_x};
        if (clr_last) nstate = S_LOAD;
      end
`endif
      S_LOAD: begin
        bus.gray_req  = 1'b1;
        bus.gray_addr = {rd_y, rd_x};
        if (last_rd) nstate = S_EVAL;
      end
      S_EVAL: begin
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = {y, x};
        // Window is registered, so the code is stable for the whole cycle.
        bus.lbp_data  = code;
        nstate        = scan_end ? S_DONE : S_LOAD;
      end
      S_DONE:  nstate = S_DONE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x    <= ONE;
      y    <= ONE;
      fr   <= '0;
      fc   <= '0;
      full <= 1'b1;
      win  <= '0;
    end else begin
      if (accept) begin
        win[fr][wcol] <= bus.gray_data;
        if (fr == 2'd2) begin
          fr <= '0;
          if (full && fc != 2'd2) begin
            fc <= fc + 2'd1;
          end else begin
            fc   <= '0;
            full <= 1'b0;
          end
        end else begin
          fr <= fr + 2'd1;
        end
      end
      if (state == S_EVAL && !scan_end) begin
        if (row_end) begin
          x    <= ONE;
          y    <= y + ONE;
          full <= 1'b1;
        end else begin
          x <= x + ONE;
          // Shift left; the next fetch refills column 2.
          for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
          end
        end
      end
    end
  end

endmodule

// File: doc/lbp_scan_ctrl.md
# lbp_scan_ctrl

Sequencer for the 128x128 LBP engine. It owns the gray-image read handshake (`gray_req`/`gray_ready`), builds a sliding 3x3 window column by column, and evaluates one interior LBP code per window. It writes each code to the LBP result memory through `lbp_valid`/`lbp_addr`/`lbp_data` and raises `finish` when the scan is complete. It is the top-level `LBP`-side controller; both memories are external.

## Interface
- `IMG_LOG2`, default 7: log2 of the image side; side = 2**IMG_LOG2 (128).
- `ADDR_W`, default 14: address width, = 2*IMG_LOG2.
- `clk`  in  1: single clock, all logic on posedge.
- `reset`  in  1: synchronous and active-high.
- `gray_ready`  in  1: gray memory may be read; low = stall.
- `gray_data`  in  8: pixel at `gray_addr`, valid in the same cycle `gray_req` is high.
- `gray_req`  out  1: read request.
- `gray_addr`  out  ADDR_W: read address = {y, x}.
- `lbp_valid`  out  1: write strobe to the LBP memory, sampled by the memory at negedge.
- `lbp_addr`  out  ADDR_W: write address = {y, x}.
- `lbp_data`  out  8: LBP code.
- `finish`  out  1: scan done; held until reset.

## Operation
- FSM states are IDLE, WAIT_RDY, (CLEAR), LOAD, EVAL and DONE.
  - IDLE goes to WAIT_RDY on the first cycle after reset.
  - WAIT_RDY goes to LOAD (or CLEAR) when `gray_ready` = 1.
- Scan covers interior pixels only: y = 1..126 and x = 1..126, in raster order. Border pixels are not computed.
- Row start: LOAD fetches 3 columns (x-1, x, x+1), 9 reads in total, then goes to EVAL.
- Steady state: after EVAL for pixel x, LOAD fetches only column x+2 (3 reads, rows y-1, y, y+1 in that order).
  - The window shifts left and the new column enters on the right.
  - Then EVAL runs.
- EVAL lasts one cycle, with `lbp_valid` = 1, `lbp_addr` = {y, x} and `lbp_data` = registered code.
  - After x = 126, the next row starts.
  - After (126, 126), the FSM goes to DONE.
- Read capture: a pixel is accepted at a posedge where `gray_req` && `gray_ready`. The fetch counter advances only on accept.
- `gray_req` = 1 only in LOAD (and never in CLEAR); otherwise 0.
- Code: bit k = (neighbour k >= centre), unsigned 8-bit compare. Neighbour order:
  - k0 = (x-1, y-1), k1 = (x, y-1), k2 = (x+1, y-1)
  - k3 = (x-1, y), k4 = (x+1, y)
  - k5 = (x-1, y+1), k6 = (x, y+1), k7 = (x+1, y+1)
- Address arithmetic is a concatenation of 7-bit x and y. No multiplier. Counters never wrap past 127.

## Timing
- Reset values: `gray_req`, `lbp_valid` and `finish` = 0; `gray_addr`, `lbp_addr` and `lbp_data` = 0. The state returns to IDLE on the edge where `reset` is sampled high. This applies mid-scan too: window, counters and `finish` are cleared, and no partial write is issued afterward.
- Read latency is 0: data is consumed at the posedge closing the request cycle.
- First window: reads at addresses 0, 128, 256, 1, 129, 257, 2, 130, 258. The 10th cycle is EVAL with `lbp_addr` = 129.
- Per row: 9 + 125*3 reads + 126 EVAL = 510 cycles. The full scan is 64260 cycles from the first `gray_req` to the last `lbp_valid`, with no stalls.
- Stall: if `gray_ready` = 0 during LOAD, `gray_req` stays asserted, the address is held and nothing is captured. The total cycle count grows by exactly the stall cycles.
- `finish` rises the cycle after the last EVAL, while `lbp_valid` = 0.

## Configuration
- `LBP_BORDER_CLEAR_EN` defined: CLEAR runs before the scan. It writes `lbp_data` = 0 to all 508 border addresses (rows 0 and 127, then columns 0 and 127 of rows 1..126), one per cycle with `lbp_valid` = 1. This adds 508 cycles.
- Macro undefined: CLEAR is absent and the border is never written; the memory is relied on to be pre-zeroed.

## Structure
- Shared package `lbp_pkg` holds:
  - the `IMG_LOG2` and `ADDR_W` constants
  - the FSM state enum
  - the neighbour bit-index constants
- One sub-module, `lbp_code_calc`: combinational, 9 pixels in, 8-bit code out. It is reused by future multi-lane variants.
- Window storage is 3x3 by 8-bit registers in the controller.

## Test plan
- All-zero image: every interior code = 0xFF; border = 0; total 64260 cycles to the last write.
- Ramp, gray[y*128+x] = x: every interior code = 0xD6.
- Single 255 at (64,64), rest 0: code(64,64) = 0x00; code(65,64) = 0xFF; code(63,63) = 0xFF.
- `gray_ready` low for 5 cycles mid-row 40: same 16384-entry result as the unstalled run; finish is 5 cycles later; `gray_addr` is held during the stall.
- `reset` pulsed at cycle 30000, then rerun: final memory matches golden; no `lbp_valid` during or right after the reset cycle.
- With `LBP_BORDER_CLEAR_EN`, memory pre-filled with 0xAA: all 508 border entries = 0; interior matches golden; scan starts 508 cycles later.
